// File: rtl/gray_sync_decoder.sv
// Synchronizes an asynchronous Gray code, decodes it to binary, and classifies each
// sampled change as a +1 step, a -1 step, or an illegal multi-bit jump with a saturating error count.
module gray_sync_decoder #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     gray_async,
    input  logic                 clr_err,
    output logic [WIDTH-1:0]     gray_sync,
    output logic [WIDTH-1:0]     bin,
    output logic                 step_up,
    output logic                 step_dn,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 primed
);

    localparam int PCW = $clog2(SYNC_STAGES + 1);

    logic [WIDTH-1:0]     sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]     sync_d [SYNC_STAGES];
    logic [PCW-1:0]       prime_cnt_q, prime_cnt_d;
    logic [WIDTH-1:0]     gray_sync_q, gray_sync_d;
    logic [WIDTH-1:0]     bin_q, bin_d;
    logic                 step_up_q, step_up_d;
    logic                 step_dn_q, step_dn_d;
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 primed_q, primed_d;

    logic [WIDTH-1:0]     s_gray;
    logic [WIDTH-1:0]     diff;
    logic [WIDTH-1:0]     new_bin;
    logic                 one_bit;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = '0;
        b[WIDTH-1] = g[WIDTH-1];
        for (int unsigned k = 1; k < WIDTH; k++) begin
            b[WIDTH-1-k] = b[WIDTH-k] ^ g[WIDTH-1-k];
        end
        return b;
    endfunction

    assign s_gray = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d[0] = gray_async;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_comb begin
        prime_cnt_d = prime_cnt_q;
        gray_sync_d = gray_sync_q;
        bin_d       = bin_q;
        step_up_d   = 1'b0;
        step_dn_d   = 1'b0;
        err_d       = 1'b0;
        err_cnt_d   = err_cnt_q;
        primed_d    = primed_q;

        diff    = s_gray ^ gray_sync_q;
        new_bin = gray2bin(s_gray);
        // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
        one_bit = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);

        if (!primed_q) begin
            if (prime_cnt_q == PCW'(SYNC_STAGES)) begin
                gray_sync_d = s_gray;
                bin_d       = new_bin;
                primed_d    = 1'b1;
            end else begin
                prime_cnt_d = prime_cnt_q + PCW'(1);
            end
        end else if (diff != '0) begin
            gray_sync_d = s_gray;
            bin_d       = new_bin;
            if (one_bit) begin
                if (new_bin == bin_q + WIDTH'(1)) begin
                    step_up_d = 1'b1;
                end else begin
                    step_dn_d = 1'b1;
                end
            end else begin
                err_d = 1'b1;
                if (err_cnt_q != '1) begin
                    err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                end
            end
        end

        if (clr_err) begin
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prime_cnt_q <= '0;
            gray_sync_q <= '0;
            bin_q       <= '0;
            step_up_q   <= 1'b0;
            step_dn_q   <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
            primed_q    <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            prime_cnt_q <= prime_cnt_d;
            gray_sync_q <= gray_sync_d;
            bin_q       <= bin_d;
            step_up_q   <= step_up_d;
            step_dn_q   <= step_dn_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
            primed_q    <= primed_d;
        end
    end

    assign gray_sync = gray_sync_q;
    assign bin       = bin_q;
    assign step_up   = step_up_q;
    assign step_dn   = step_dn_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;
    assign primed    = primed_q;

endmodule

// File: tb/tb_gray_sync_decoder.sv
// Self-checking bench for gray_sync_decoder: directed scenarios plus random Gray traffic,
// compared every cycle against a sample-history reference model.
module tb_gray_sync_decoder;

    localparam int W = 4;
    localparam int S = 2;
    localparam int E = 8;
    localparam int MAXV = (1 << W);
    localparam int CMAX = (1 << E) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] gray_async;
    logic         clr_err;
    logic [W-1:0] gray_sync;
    logic [W-1:0] bin;
    logic         step_up;
    logic         step_dn;
    logic         err;
    logic [E-1:0] err_cnt;
    logic         primed;

    int n_checks = 0;
    int n_fail   = 0;
    int n_up = 0, n_dn = 0, n_err = 0;

    gray_sync_decoder #(
        .WIDTH      (W),
        .SYNC_STAGES(S),
        .ERR_CNT_W  (E)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .gray_async(gray_async),
        .clr_err   (clr_err),
        .gray_sync (gray_sync),
        .bin       (bin),
        .step_up   (step_up),
        .step_dn   (step_dn),
        .err       (err),
        .err_cnt   (err_cnt),
        .primed    (primed)
    );

    always #5 clk = ~clk;

    function automatic int to_gray(input int b);
        return (b ^ (b >> 1)) & (MAXV - 1);
    endfunction

    // Decode by searching for the binary value whose Gray encoding matches.
    function automatic int from_gray(input int g);
        for (int b = 0; b < MAXV; b++) begin
            if (to_gray(b) == g) return b;
        end
        return -1;
    endfunction

    // Reference model: history of sampled inputs, updated on each rising edge.
    int m_hist [S];
    int m_since = 0;
    int m_gs = 0, m_bin = 0, m_cnt = 0;
    bit m_up = 0, m_dn = 0, m_err = 0, m_primed = 0;

    always @(posedge clk) begin
        int sg, nb, hd;
        if (rst) begin
            for (int i = 0; i < S; i++) m_hist[i] = 0;
            m_since = 0; m_gs = 0; m_bin = 0; m_cnt = 0;
            m_up = 0; m_dn = 0; m_err = 0; m_primed = 0;
        end else begin
            sg = m_hist[S-1];
            for (int i = S - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = int'(gray_async);
            m_up = 0; m_dn = 0; m_err = 0;
            if (!m_primed) begin
                if (m_since == S) begin
                    m_gs = sg; m_bin = from_gray(sg); m_primed = 1;
                end else begin
                    m_since++;
                end
            end else if (sg != m_gs) begin
                nb = from_gray(sg);
                hd = $countones(sg ^ m_gs);
                if (hd == 1) begin
                    if ((nb - m_bin + MAXV) % MAXV == 1) m_up = 1;
                    else m_dn = 1;
                end else begin
                    m_err = 1;
                    if (m_cnt < CMAX) m_cnt++;
                end
                m_gs = sg; m_bin = nb;
            end
            if (clr_err) m_cnt = 0;
        end
    end

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one cycle, then compare every output against the model.
    task automatic tick();
        @(negedge clk);
        check_eq("gray_sync", gray_sync, m_gs);
        check_eq("bin", bin, m_bin);
        check_eq("step_up", step_up, m_up);
        check_eq("step_dn", step_dn, m_dn);
        check_eq("err", err, m_err);
        check_eq("err_cnt", err_cnt, m_cnt);
        check_eq("primed", primed, m_primed);
        n_up  += int'(step_up);
        n_dn  += int'(step_dn);
        n_err += int'(err);
    endtask

    task automatic hold(input int g, input int cycles);
        gray_async = W'(g);
        repeat (cycles) tick();
    endtask

    initial begin
        int cur, up0, dn0, err0, nxt;

        rst = 1'b1; clr_err = 1'b0; gray_async = 4'b1010;
        repeat (3) tick();
        check_eq("rst_bin", bin, 0);
        check_eq("rst_primed", primed, 0);

        // Priming
        rst = 1'b0; gray_async = 4'b0110;
        tick(); tick();
        check_eq("prime_early", primed, 0);
        tick();
        check_eq("prime_done", primed, 1);
        check_eq("prime_bin", bin, 4);
        check_eq("prime_gs", gray_sync, 4'b0110);
        check_eq("prime_pulses", step_up | step_dn | err, 0);

        // Move to 0000 (a 2-bit jump) and clear the resulting count
        hold(0, 4);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        check_eq("clr_cnt", err_cnt, 0);

        // Up count with wrap
        up0 = n_up; err0 = n_err;
        for (int b = 1; b <= MAXV; b++) hold(to_gray(b % MAXV), 4);
        check_eq("up_pulses", n_up - up0, 16);
        check_eq("up_errs", n_err - err0, 0);
        check_eq("up_wrap_bin", bin, 0);

        // Down with wrap
        dn0 = n_dn;
        hold(4'b1000, 4);
        check_eq("dn_wrap_bin", bin, 15);
        hold(4'b1001, 4);
        check_eq("dn_bin", bin, 14);
        check_eq("dn_pulses", n_dn - dn0, 2);

        // Errors and saturation
        hold(0, 4);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        hold(4'b0011, 4);
        check_eq("err_bin", bin, 2);
        check_eq("err_cnt1", err_cnt, 1);
        for (int i = 0; i < 300; i++) hold((i % 2 == 0) ? 0 : 3, 2);
        hold(3, 2);
        check_eq("err_sat", err_cnt, CMAX);
        gray_async = 4'b0000; tick(); tick();
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        check_eq("clr_vs_err_pulse", err, 1);
        check_eq("clr_vs_err_cnt", err_cnt, 0);

        // Reset mid-operation discards the in-flight change
        hold(4'b0001, 4);
        up0 = n_up;
        gray_async = 4'b0011; tick();
        rst = 1'b1; tick();
        check_eq("midrst_bin", bin, 0);
        tick();
        rst = 1'b0; repeat (3) tick();
        check_eq("reprime_bin", bin, 2);
        check_eq("reprime_primed", primed, 1);
        check_eq("midrst_pulses", n_up - up0, 0);

        // Random traffic: mostly single steps, some jumps, occasional clears and resets
        cur = 2;
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: nxt = (cur + 1) % MAXV;
                3, 4:    nxt = (cur + MAXV - 1) % MAXV;
                5:       nxt = int'($urandom_range(0, MAXV - 1));
                default: nxt = cur;
            endcase
            cur = nxt;
            gray_async = W'(to_gray(cur));
            clr_err = ($urandom_range(0, 29) == 0);
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0; clr_err = 1'b0;
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
